serdes_decoder: RTL and testbench

SERDES_DECODER -- requirements
Module: serdes_decoder

---
 rtl/serdes_pkg.sv | 63 ++++++
 rtl/serdes_10b8b_lut.sv | 124 ++++++++++++
 rtl/serdes_decoder.sv | 114 +++++++++++
 tb/tb_serdes_decoder.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/serdes_pkg.sv
// Shared types and constants for the 8b/10b serial decoder: FSM states,
// comma patterns, K-code values and the sub-block disparity helpers.
package serdes_pkg;

  typedef enum logic {HUNT, LOCKED} state_t;

  typedef enum logic [2:0] {
    DC_NEUTRAL,
    DC_POS,
    DC_NEG,
    DC_SET_POS,
    DC_SET_NEG
  } disp_class_t;

  localparam logic [6:0] COMMA_NEG = 7'b0011111;
  localparam logic [6:0] COMMA_POS = 7'b1100000;

  localparam logic [7:0] K28_0 = 8'h1C;
  localparam logic [7:0] K28_1 = 8'h3C;
  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K28_7 = 8'hFC;
  localparam logic [7:0] K23_7 = 8'hF7;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K29_7 = 8'hFD;
  localparam logic [7:0] K30_7 = 8'hFE;

  localparam int LOSS_THRESH_DEFAULT = 4;

  // Balanced 000111/0011 force RD+ and 111000/1100 force RD-; 4b blocks arrive zero-extended.
  function automatic disp_class_t classify(input logic [5:0] sub, input logic wide);
    int ones;
    int half;
    disp_class_t c;
    ones = $countones(sub);
    half = wide ? 3 : 2;
    if (ones > half)
      c = DC_POS;
    else if (ones < half)
      c = DC_NEG;
    else if (wide ? (sub == 6'b000111) : (sub[3:0] == 4'b0011))
      c = DC_SET_POS;
    else if (wide ? (sub == 6'b111000) : (sub[3:0] == 4'b1100))
      c = DC_SET_NEG;
    else
      c = DC_NEUTRAL;
    return c;
  endfunction

  function automatic logic rd_after(input disp_class_t c, input logic rd_in);
    logic r;
    case (c)
      DC_POS, DC_SET_POS: r = 1'b1;
      DC_NEG, DC_SET_NEG: r = 1'b0;
      default:            r = rd_in;
    endcase
    return r;
  endfunction

  function automatic logic disp_violation(input disp_class_t c, input logic rd_in);
    return ((c == DC_POS) && rd_in) || ((c == DC_NEG) && !rd_in);
  endfunction

endpackage

// File: rtl/serdes_10b8b_lut.sv
// Combinational 10b-to-8b lookup: decoded byte, K flag, table hit and the
// disparity class of each sub-block. Input bit 9 is 'a', bit 0 is 'j'.
module serdes_10b8b_lut
  import serdes_pkg::*;
(
  input  logic [9:0]  code,
  output logic [7:0]  data,
  output logic        k,
  output logic        found,
  output disp_class_t disp6,
  output disp_class_t disp4
);

  logic [5:0] six;
  logic [3:0] four;
  logic [3:0] four_k;
  logic [4:0] x;
  logic [2:0] y;
  logic       x_ok;
  logic       y_ok;
  logic       k_sym;
  logic       is_k28;
  logic       k7_six;

  assign six    = code[9:4];
  assign four   = code[3:0];
  assign is_k28 = (six == 6'b001111) || (six == 6'b110000);
  assign k7_six = (six == 6'b111010) || (six == 6'b000101) || (six == 6'b110110) ||
                  (six == 6'b001001) || (six == 6'b101110) || (six == 6'b010001) ||
                  (six == 6'b011110) || (six == 6'b100001);
  // K28 RD+ uses the bitwise complement of the RD- 4b codes
  assign four_k = (six == 6'b110000) ? ~four : four;

  assign disp6 = classify(six, 1'b1);
  assign disp4 = classify({2'b00, four}, 1'b0);

  always_comb begin
    x     = '0;
    y     = '0;
    x_ok  = 1'b1;
    y_ok  = 1'b1;
    k_sym = 1'b0;

    case (six)
      6'b100111, 6'b011000: x = 5'd0;
      6'b011101, 6'b100010: x = 5'd1;
      6'b101101, 6'b010010: x = 5'd2;
      6'b110001:            x = 5'd3;
      6'b110101, 6'b001010: x = 5'd4;
      6'b101001:            x = 5'd5;
      6'b011001:            x = 5'd6;
      6'b111000, 6'b000111: x = 5'd7;
      6'b111001, 6'b000110: x = 5'd8;
      6'b100101:            x = 5'd9;
      6'b010101:            x = 5'd10;
      6'b110100:            x = 5'd11;
      6'b001101:            x = 5'd12;
      6'b101100:            x = 5'd13;
      6'b011100:            x = 5'd14;
      6'b010111, 6'b101000: x = 5'd15;
      6'b011011, 6'b100100: x = 5'd16;
      6'b100011:            x = 5'd17;
      6'b010011:            x = 5'd18;
      6'b110010:            x = 5'd19;
      6'b001011:            x = 5'd20;
      6'b101010:            x = 5'd21;
      6'b011010:            x = 5'd22;
      6'b111010, 6'b000101: x = 5'd23;
      6'b110011, 6'b001100: x = 5'd24;
      6'b100110:            x = 5'd25;
      6'b010110:            x = 5'd26;
      6'b110110, 6'b001001: x = 5'd27;
      6'b001110, 6'b001111, 6'b110000: x = 5'd28;
      6'b101110, 6'b010001: x = 5'd29;
      6'b011110, 6'b100001: x = 5'd30;
      6'b101011, 6'b010100: x = 5'd31;
      default:              x_ok = 1'b0;
    endcase

    if (is_k28) begin
      k_sym = 1'b1;
      case (four_k)
        4'b0100: y = 3'd0;
        4'b1001: y = 3'd1;
        4'b0101: y = 3'd2;
        4'b0011: y = 3'd3;
        4'b0010: y = 3'd4;
        4'b1010: y = 3'd5;
        4'b0110: y = 3'd6;
        4'b1000: y = 3'd7;
        default: y_ok = 1'b0;
      endcase
    end else begin
      case (four)
        4'b1011, 4'b0100: y = 3'd0;
        4'b1001:          y = 3'd1;
        4'b0101:          y = 3'd2;
        4'b1100, 4'b0011: y = 3'd3;
        4'b1101, 4'b0010: y = 3'd4;
        4'b1010:          y = 3'd5;
        4'b0110:          y = 3'd6;
        4'b1110, 4'b0001: y = 3'd7;
        4'b0111: begin
          y = 3'd7;
          if (x == 5'd17 || x == 5'd18 || x == 5'd20) k_sym = 1'b0;
          else if (k7_six)                             k_sym = 1'b1;
          else                                         y_ok  = 1'b0;
        end
        4'b1000: begin
          y = 3'd7;
          if (x == 5'd11 || x == 5'd13 || x == 5'd14) k_sym = 1'b0;
          else if (k7_six)                             k_sym = 1'b1;
          else                                         y_ok  = 1'b0;
        end
        default: y_ok = 1'b0;
      endcase
    end

    found = x_ok && y_ok;
    data  = found ? {y, x} : 8'h00;
    k     = found && k_sym;
  end

endmodule

// File: rtl/serdes_decoder.sv
// Serial 8b/10b receiver: hunts for a comma to align symbols, then decodes
// every tenth valid bit, tracking running disparity and loss of lock.
module serdes_decoder
  import serdes_pkg::*;
#(
  parameter int LOSS_THRESH = LOSS_THRESH_DEFAULT
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Ser_Bit,
  input  logic       i_Bit_Valid,
  output logic [7:0] o_Data,
  output logic       o_K,
  output logic       o_Valid,
  output logic       o_Code_Err,
  output logic       o_Disp_Err,
  output logic       o_Locked,
  output logic       o_RD
);

  localparam logic [4:0] THRESH = LOSS_THRESH[4:0];

  state_t      state, state_next;
  logic [9:0]  shift, shift_next;
  logic [3:0]  bit_cnt, bit_cnt_next, cnt_inc;
  logic [4:0]  err_cnt, err_next;
  logic        rd, rd_next, rd_in, rd_mid, rd_out;
  logic        sym_done, lost, disp_err;
  logic [7:0]  lut_data;
  logic        lut_k, lut_found;
  disp_class_t disp6, disp4;

  serdes_10b8b_lut u_lut (
    .code  (shift_next),
    .data  (lut_data),
    .k     (lut_k),
    .found (lut_found),
    .disp6 (disp6),
    .disp4 (disp4)
  );

  // On the locking comma the RD entering the symbol comes from the comma's own form
  assign rd_in    = (state == HUNT) ? (shift_next[9:3] == COMMA_POS) : rd;
  assign rd_mid   = rd_after(disp6, rd_in);
  assign rd_out   = rd_after(disp4, rd_mid);
  assign disp_err = disp_violation(disp6, rd_in) || disp_violation(disp4, rd_mid);
  assign lost     = (state == LOCKED) && (err_cnt >= THRESH);
  assign cnt_inc  = (bit_cnt == 4'd9) ? 4'd0 : bit_cnt + 4'd1;

  always_comb begin
    shift_next   = i_Bit_Valid ? {shift[8:0], i_Ser_Bit} : shift;
    state_next   = state;
    bit_cnt_next = bit_cnt;
    err_next     = err_cnt;
    rd_next      = rd;
    sym_done     = 1'b0;

    unique case (state)
      HUNT: begin
        if (i_Bit_Valid && ((shift_next[9:3] == COMMA_NEG) || (shift_next[9:3] == COMMA_POS))) begin
          sym_done     = 1'b1;
          state_next   = LOCKED;
          bit_cnt_next = 4'd9;
        end
      end
      LOCKED: begin
        if (lost) begin
          state_next   = HUNT;
          bit_cnt_next = 4'd0;
          err_next     = 5'd0;
        end else if (i_Bit_Valid) begin
          bit_cnt_next = cnt_inc;
          sym_done     = (cnt_inc == 4'd9);
        end
      end
      default: state_next = HUNT;
    endcase

    if (sym_done) begin
      rd_next  = rd_out;
      err_next = lut_found ? 5'd0 : ((err_cnt == 5'd31) ? err_cnt : err_cnt + 5'd1);
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state      <= HUNT;
      shift      <= '0;
      bit_cnt    <= '0;
      err_cnt    <= '0;
      rd         <= 1'b0;
      o_Valid    <= 1'b0;
      o_Data     <= '0;
      o_K        <= 1'b0;
      o_Code_Err <= 1'b0;
      o_Disp_Err <= 1'b0;
    end else begin
      state      <= state_next;
      shift      <= shift_next;
      bit_cnt    <= bit_cnt_next;
      err_cnt    <= err_next;
      rd         <= rd_next;
      o_Valid    <= sym_done;
      o_Data     <= (sym_done && lut_found) ? lut_data : 8'h00;
      o_K        <= sym_done && lut_found && lut_k;
      o_Code_Err <= sym_done && !lut_found;
      o_Disp_Err <= sym_done && lut_found && disp_err;
    end
  end

  assign o_Locked = (state == LOCKED);
  assign o_RD     = rd;

endmodule

// File: tb/tb_serdes_decoder.sv
// Directed bench for serdes_decoder: expected symbols go into a scoreboard as
// they are driven and are popped when the decoder raises o_Valid.
module tb_serdes_decoder;

  typedef struct packed {
    logic [7:0] data;
    logic       k;
    logic       ce;
    logic       de;
    logic       chk_de;
    logic       locked;
    logic       rd;
  } exp_t;

  logic       i_Clk;
  logic       i_Rst_L;
  logic       i_Ser_Bit;
  logic       i_Bit_Valid;
  logic [7:0] o_Data;
  logic       o_K;
  logic       o_Valid;
  logic       o_Code_Err;
  logic       o_Disp_Err;
  logic       o_Locked;
  logic       o_RD;

  int    assertCount = 0;
  int    failCount   = 0;
  exp_t  expQ[$];
  string tagQ[$];

  serdes_decoder #(.LOSS_THRESH(4)) dut (
    .i_Clk       (i_Clk),
    .i_Rst_L     (i_Rst_L),
    .i_Ser_Bit   (i_Ser_Bit),
    .i_Bit_Valid (i_Bit_Valid),
    .o_Data      (o_Data),
    .o_K         (o_K),
    .o_Valid     (o_Valid),
    .o_Code_Err  (o_Code_Err),
    .o_Disp_Err  (o_Disp_Err),
    .o_Locked    (o_Locked),
    .o_RD        (o_RD)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic exp_t mkExp(input logic [7:0] d, input logic k, input logic ce,
                                 input logic de, input logic chk, input logic lk, input logic rd);
    exp_t e;
    e.data = d; e.k = k; e.ce = ce; e.de = de; e.chk_de = chk; e.locked = lk; e.rd = rd;
    return e;
  endfunction

  task automatic checkVal(input string name, input logic [7:0] obs, input logic [7:0] expv);
    assertCount++;
    assert (obs === expv) else begin
      failCount++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", name, obs, expv);
    end
  endtask

  task automatic checkIdle();
    checkVal("idle flags", {4'b0000, o_Valid, o_K, o_Code_Err, o_Disp_Err}, 8'h00);
    checkVal("idle data", o_Data, 8'h00);
  endtask

  task automatic sendBit(input logic b);
    @(negedge i_Clk);
    checkIdle();
    i_Ser_Bit   = b;
    i_Bit_Valid = 1'b1;
  endtask

  task automatic idleCycle();
    @(negedge i_Clk);
    checkIdle();
    i_Bit_Valid = 1'b0;
    i_Ser_Bit   = 1'($urandom_range(0, 1));
  endtask

  task automatic applyStimulus(input logic [9:0] sym, input exp_t e, input string tag);
    expQ.push_back(e);
    tagQ.push_back(tag);
    for (int i = 9; i >= 0; i--) begin
      if ($urandom_range(0, 3) == 0) idleCycle();
      sendBit(sym[i]);
    end
  endtask

  task automatic checkOutput();
    exp_t  e;
    string tag;
    bit    seen;
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(negedge i_Clk);
      i_Bit_Valid = 1'b0;
      if (o_Valid === 1'b1) seen = 1'b1;
    end
    e   = expQ.pop_front();
    tag = tagQ.pop_front();
    checkVal({tag, " valid"}, {7'd0, seen}, 8'd1);
    checkVal({tag, " data"}, o_Data, e.data);
    checkVal({tag, " k"}, {7'd0, o_K}, {7'd0, e.k});
    checkVal({tag, " code_err"}, {7'd0, o_Code_Err}, {7'd0, e.ce});
    if (e.chk_de) checkVal({tag, " disp_err"}, {7'd0, o_Disp_Err}, {7'd0, e.de});
    checkVal({tag, " locked"}, {7'd0, o_Locked}, {7'd0, e.locked});
    checkVal({tag, " rd"}, {7'd0, o_RD}, {7'd0, e.rd});
  endtask

  task automatic checkAllZero(input string tag);
    checkVal({tag, " flags"}, {1'b0, o_Valid, o_K, o_Code_Err, o_Disp_Err, o_Locked, o_RD, 1'b0}, 8'h00);
    checkVal({tag, " data"}, o_Data, 8'h00);
  endtask

  task automatic doReset(input string tag);
    @(negedge i_Clk);
    i_Rst_L     = 1'b0;
    i_Bit_Valid = 1'b0;
    repeat (2) @(negedge i_Clk);
    checkAllZero(tag);
    i_Rst_L = 1'b1;
  endtask

  initial begin
    i_Rst_L     = 1'b0;
    i_Bit_Valid = 1'b0;
    i_Ser_Bit   = 1'b0;

    // Lock on K28.5 RD-, then a run of data and control symbols with RD tracking
    doReset("reset");
    applyStimulus(10'b0011111010, mkExp(8'hBC, 1, 0, 0, 1, 1, 1), "k28_5 lock");
    checkOutput();
    applyStimulus(10'b1010101010, mkExp(8'hB5, 0, 0, 0, 1, 1, 1), "d21_5");
    checkOutput();
    applyStimulus(10'b1001110100, mkExp(8'h00, 0, 0, 1, 1, 1, 0), "d0_0 disp");
    checkOutput();
    applyStimulus(10'b0101010101, mkExp(8'h4A, 0, 0, 0, 1, 1, 0), "d10_2");
    checkOutput();
    applyStimulus(10'b1000110111, mkExp(8'hF1, 0, 0, 0, 1, 1, 1), "d17_a7");
    checkOutput();
    applyStimulus(10'b0001010111, mkExp(8'hF7, 1, 0, 0, 1, 1, 1), "k23_7");
    checkOutput();
    applyStimulus(10'b1100000101, mkExp(8'hBC, 1, 0, 0, 1, 1, 0), "k28_5 rd+");
    checkOutput();
    applyStimulus(10'b1100011100, mkExp(8'h63, 0, 0, 0, 1, 1, 0), "d3_3");
    checkOutput();

    // Four consecutive code errors drop lock one cycle after the fourth
    doReset("reset loss");
    applyStimulus(10'b0011111010, mkExp(8'hBC, 1, 0, 0, 1, 1, 1), "loss lock");
    checkOutput();
    for (int n = 0; n < 4; n++) begin
      applyStimulus(10'b1111111111, mkExp(8'h00, 0, 1, 0, 0, 1, 1), "code err");
      checkOutput();
    end
    @(negedge i_Clk);
    checkVal("loss locked", {7'd0, o_Locked}, 8'd0);
    checkVal("loss valid", {7'd0, o_Valid}, 8'd0);

    // Reset in the middle of a symbol while i_Bit_Valid toggles
    doReset("reset mid");
    applyStimulus(10'b0011111010, mkExp(8'hBC, 1, 0, 0, 1, 1, 1), "mid lock");
    checkOutput();
    sendBit(1'b1); idleCycle(); sendBit(1'b0); idleCycle();
    sendBit(1'b0); sendBit(1'b1); idleCycle(); sendBit(1'b1);
    @(negedge i_Clk);
    i_Rst_L = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge i_Clk);
      i_Bit_Valid = ~i_Bit_Valid;
      i_Ser_Bit   = 1'($urandom_range(0, 1));
      checkAllZero("in reset");
    end
    i_Rst_L = 1'b1;
    sendBit(1'b1); sendBit(1'b0); sendBit(1'b1); sendBit(1'b0); sendBit(1'b0);
    repeat (12) idleCycle();
    @(negedge i_Clk);
    checkVal("after mid locked", {7'd0, o_Locked}, 8'd0);
    checkVal("after mid rd", {7'd0, o_RD}, 8'd0);

    // Junk bits ahead of the comma: alignment must follow the comma
    doReset("reset junk");
    sendBit(1'b1); sendBit(1'b0); sendBit(1'b1);
    applyStimulus(10'b0011111010, mkExp(8'hBC, 1, 0, 0, 1, 1, 1), "junk lock");
    checkOutput();
    applyStimulus(10'b1010101010, mkExp(8'hB5, 0, 0, 0, 1, 1, 1), "junk d21_5");
    checkOutput();
    applyStimulus(10'b0101010101, mkExp(8'h4A, 0, 0, 0, 1, 1, 1), "junk d10_2");
    checkOutput();
    applyStimulus(10'b1100010011, mkExp(8'h63, 0, 0, 0, 1, 1, 1), "junk d3_3");
    checkOutput();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
